// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared 32-bit ALU.
// A granted request is registered onto the ALU inputs for one cycle, the ALU
// result and flags are then registered as a response held until it is consumed.
module alu_share_arbiter #(
  parameter int unsigned OP_W  = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  // request side
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [2*OP_W-1:0] req_op,
  input  logic [63:0]       req_a,
  input  logic [63:0]       req_b,
  // shared ALU
  output logic [OP_W-1:0]   alu_op,
  output logic [31:0]       alu_a,
  output logic [31:0]       alu_b,
  input  logic [31:0]       alu_result,
  input  logic              alu_zero,
  input  logic              alu_less,
  input  logic              alu_ovf,
  // response side
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [31:0]       rsp_data,
  output logic              rsp_zero,
  output logic              rsp_less,
  output logic              rsp_ovf,
  output logic              rsp_err,
  output logic [CNT_W-1:0]  ops_done
);

  // Opcodes the shared ALU does not implement.
  localparam logic [OP_W-1:0] OpUnsupA = OP_W'(4'b1100);
  localparam logic [OP_W-1:0] OpUnsupB = OP_W'(4'b1101);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StExec = 2'd1,
    StResp = 2'd2
  } state_e;

  state_e state_q, state_d;

  logic             rr_q, rr_d;
  logic             gnt_q, gnt_d;
  logic [OP_W-1:0]  alu_op_q, alu_op_d;
  logic [31:0]      alu_a_q, alu_a_d;
  logic [31:0]      alu_b_q, alu_b_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_id_q, rsp_id_d;
  logic [31:0]      rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_less_q, rsp_less_d;
  logic             rsp_ovf_q, rsp_ovf_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] ops_done_q, ops_done_d;

  logic gnt_any;
  logic gnt_idx;
  logic accept;
  logic rsp_hs;
  logic op_unsup;

  // Grant selection: a lone requester wins, contention is settled by rr_q.
  always_comb begin
    gnt_any = |req_valid;
    gnt_idx = 1'b0;
    case (req_valid)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = rr_q;
      default: gnt_idx = 1'b0;
    endcase
  end

  assign accept   = (state_q == StIdle) && gnt_any;
  assign rsp_hs   = (state_q == StResp) && rsp_ready;
  assign op_unsup = (alu_op_q == OpUnsupA) || (alu_op_q == OpUnsupB);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: EXEC is always a single cycle, RESP waits for the consumer.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (gnt_any)   state_d = StExec;
      StExec:                 state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default:                state_d = StIdle;
    endcase
  end

  // FSM outputs: one-hot ready on the granted requester, only while idle.
  always_comb begin
    req_ready = 2'b00;
    if (state_q == StIdle && gnt_any) begin
      req_ready[gnt_idx] = 1'b1;
    end
  end

  // Datapath next state: capture on accept, latch ALU on EXEC, retire on handshake.
  always_comb begin
    rr_d        = rr_q;
    gnt_d       = gnt_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    rsp_zero_d  = rsp_zero_q;
    rsp_less_d  = rsp_less_q;
    rsp_ovf_d   = rsp_ovf_q;
    rsp_err_d   = rsp_err_q;
    ops_done_d  = ops_done_q;

    if (accept) begin
      gnt_d = gnt_idx;
      if (gnt_idx) begin
        alu_op_d = req_op[2*OP_W-1:OP_W];
        alu_a_d  = req_a[63:32];
        alu_b_d  = req_b[63:32];
      end else begin
        alu_op_d = req_op[OP_W-1:0];
        alu_a_d  = req_a[31:0];
        alu_b_d  = req_b[31:0];
      end
    end

    if (state_q == StExec) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = gnt_q;
      if (op_unsup) begin
        rsp_data_d = '0;
        rsp_zero_d = 1'b0;
        rsp_less_d = 1'b0;
        rsp_ovf_d  = 1'b0;
        rsp_err_d  = 1'b1;
      end else begin
        rsp_data_d = alu_result;
        rsp_zero_d = alu_zero;
        rsp_less_d = alu_less;
        rsp_ovf_d  = alu_ovf;
        rsp_err_d  = 1'b0;
      end
    end

    if (rsp_hs) begin
      rsp_valid_d = 1'b0;
      rr_d        = ~gnt_q;
      if (ops_done_q != {CNT_W{1'b1}}) begin
        ops_done_d = ops_done_q + CNT_W'(1);
      end
    end
  end

  // Datapath registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= 1'b0;
      gnt_q       <= 1'b0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_data_q  <= '0;
      rsp_zero_q  <= 1'b0;
      rsp_less_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      rsp_err_q   <= 1'b0;
      ops_done_q  <= '0;
    end else begin
      rr_q        <= rr_d;
      gnt_q       <= gnt_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_zero_q  <= rsp_zero_d;
      rsp_less_q  <= rsp_less_d;
      rsp_ovf_q   <= rsp_ovf_d;
      rsp_err_q   <= rsp_err_d;
      ops_done_q  <= ops_done_d;
    end
  end

  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;
  assign rsp_less  = rsp_less_q;
  assign rsp_ovf   = rsp_ovf_q;
  assign rsp_err   = rsp_err_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: table of single operations plus
// contention, backpressure, mid-op reset and counter saturation sequences.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_valid;
  logic [7:0]  req_op;
  logic [63:0] req_a, req_b;
  logic        rsp_ready;

  logic [1:0]  req_ready,  req_ready2;
  logic [3:0]  alu_op,     alu_op2;
  logic [31:0] alu_a,      alu_a2, alu_b, alu_b2;
  logic [31:0] alu_result, alu_result2;
  logic        alu_zero, alu_zero2, alu_less, alu_less2, alu_ovf, alu_ovf2;
  logic        rsp_valid,  rsp_valid2, rsp_id, rsp_id2;
  logic [31:0] rsp_data,   rsp_data2;
  logic        rsp_zero, rsp_zero2, rsp_less, rsp_less2, rsp_ovf, rsp_ovf2;
  logic        rsp_err, rsp_err2;
  logic [15:0] ops_done;
  logic [1:0]  ops_done2;

  always #5 clk = ~clk;

  // Reference ALU: 0 add, 1 sub, 2 and, 3 or, anything else xor.
  function automatic logic [34:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    logic [31:0] r;
    logic        ovf;
    ovf = 1'b0;
    case (op)
      4'h0: begin r = a + b; ovf = (a[31] == b[31]) && (r[31] != a[31]); end
      4'h1: begin r = a - b; ovf = (a[31] != b[31]) && (r[31] != a[31]); end
      4'h2: r = a & b;
      4'h3: r = a | b;
      default: r = a ^ b;
    endcase
    return {ovf, ($signed(a) < $signed(b)), (r == 32'd0), r};
  endfunction

  assign {alu_ovf, alu_less, alu_zero, alu_result}     = alu_model(alu_op, alu_a, alu_b);
  assign {alu_ovf2, alu_less2, alu_zero2, alu_result2} = alu_model(alu_op2, alu_a2, alu_b2);

  alu_share_arbiter #(.OP_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .alu_zero(alu_zero), .alu_less(alu_less), .alu_ovf(alu_ovf),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_less(rsp_less), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .ops_done(ops_done)
  );

  // Narrow-counter copy fed identical stimulus, used for the saturation check.
  alu_share_arbiter #(.OP_W(4), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready2), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_op(alu_op2), .alu_a(alu_a2), .alu_b(alu_b2), .alu_result(alu_result2),
    .alu_zero(alu_zero2), .alu_less(alu_less2), .alu_ovf(alu_ovf2),
    .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready), .rsp_id(rsp_id2), .rsp_data(rsp_data2),
    .rsp_zero(rsp_zero2), .rsp_less(rsp_less2), .rsp_ovf(rsp_ovf2), .rsp_err(rsp_err2),
    .ops_done(ops_done2)
  );

  typedef struct {
    logic        who;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        z;
    logic        l;
    logic        o;
    logic        e;
  } vec_t;

  vec_t vecs[8];
  int   n_checks = 0;
  int   n_errors = 0;
  int   exp_ops  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic who, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
    if (who) begin
      req_op[7:4] = op; req_a[63:32] = a; req_b[63:32] = b;
    end else begin
      req_op[3:0] = op; req_a[31:0]  = a; req_b[31:0]  = b;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, " rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({tag, " rsp_id"},    32'(rsp_id), 32'd0);
    chk({tag, " rsp_data"},  rsp_data, 32'd0);
    chk({tag, " rsp_flags"}, 32'({rsp_zero, rsp_less, rsp_ovf, rsp_err}), 32'd0);
    chk({tag, " alu_op"},    32'(alu_op), 32'd0);
    chk({tag, " alu_a"},     alu_a, 32'd0);
    chk({tag, " alu_b"},     alu_b, 32'd0);
    chk({tag, " req_ready"}, 32'(req_ready), 32'd0);
    chk({tag, " ops_done"},  32'(ops_done), 32'd0);
  endtask

  // One isolated operation: accept, 2-edge latency, response content, handshake.
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clk);
    drive_req(v.who, v.op, v.a, v.b);
    req_valid = v.who ? 2'b10 : 2'b01;
    #1;
    chk({t, " req_ready"}, 32'(req_ready), v.who ? 32'd2 : 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    chk({t, " rsp_valid early"}, 32'(rsp_valid), 32'd0);
    chk({t, " alu_op"}, 32'(alu_op), 32'(v.op));
    chk({t, " alu_a"}, alu_a, v.a);
    @(negedge clk);
    #1;
    chk({t, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({t, " rsp_id"}, 32'(rsp_id), 32'(v.who));
    chk({t, " rsp_data"}, rsp_data, v.data);
    chk({t, " flags"}, 32'({rsp_zero, rsp_less, rsp_ovf, rsp_err}), 32'({v.z, v.l, v.o, v.e}));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops++;
    #1;
    chk({t, " rsp_valid cleared"}, 32'(rsp_valid), 32'd0);
    chk({t, " ops_done"}, 32'(ops_done), 32'(exp_ops));
  endtask

  initial begin
    logic g[4];
    logic r[4];
    int   ng, nr;
    logic seen;

    vecs[0] = '{1'b0, 4'h0, 32'd5, 32'd7, 32'd12, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 4'h1, 32'd7, 32'd7, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 4'h0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 4'h1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 4'hD, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[5] = '{1'b0, 4'hC, 32'd5, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 4'h2, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000,
                1'b0, 1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 4'hE, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0,
                1'b0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; req_valid = 2'b00; req_op = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_idle_outputs("reset");
    rst = 1'b0;

    // No request: stay idle with no grant.
    @(negedge clk);
    #1;
    chk("no_req req_ready", 32'(req_ready), 32'd0);
    chk("no_req rsp_valid", 32'(rsp_valid), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Contention from a fresh reset: rr starts at 0, grants alternate.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_ops = 0;
    drive_req(1'b0, 4'h0, 32'd1, 32'd1);
    drive_req(1'b1, 4'h0, 32'd2, 32'd2);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    ng = 0; nr = 0;
    for (int c = 0; c < 40 && (ng < 4 || nr < 4); c++) begin
      #1;
      if (req_ready != 2'b00 && ng < 4) begin g[ng] = req_ready[1]; ng++; end
      if (rsp_valid && nr < 4) begin r[nr] = rsp_id; nr++; end
      if (ng < 4 || nr < 4) @(negedge clk);
    end
    req_valid = 2'b00;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops += 4;
    chk("contention grants", 32'(ng), 32'd4);
    chk("contention rsps", 32'(nr), 32'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("contention grant%0d", i), 32'(g[i]), 32'(i % 2));
      chk($sformatf("contention rsp_id%0d", i), 32'(r[i]), 32'(i % 2));
    end
    #1;
    chk("contention ops_done", 32'(ops_done), 32'(exp_ops));

    // Backpressure: req0 served while req1 waits; response held 5 cycles.
    @(negedge clk);
    drive_req(1'b0, 4'h0, 32'd10, 32'd20);
    drive_req(1'b1, 4'h1, 32'd9, 32'd4);
    req_valid = 2'b01;
    #1;
    chk("bp grant0", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b11;
    @(negedge clk);
    for (int c = 0; c < 6; c++) begin
      #1;
      chk("bp rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp rsp_data", rsp_data, 32'd30);
      chk("bp rsp_id", 32'(rsp_id), 32'd0);
      chk("bp req_ready", 32'(req_ready), 32'd0);
      if (c < 5) @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("bp single rsp", 32'(rsp_valid), 32'd0);
    chk("bp waiting grant1", 32'(req_ready), 32'd2);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    #1;
    chk("bp rsp1 valid", 32'(rsp_valid), 32'd1);
    chk("bp rsp1 id", 32'(rsp_id), 32'd1);
    chk("bp rsp1 data", rsp_data, 32'd5);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_ops += 2;
    #1;
    chk("bp ops_done", 32'(ops_done), 32'(exp_ops));

    // Reset during EXEC discards the operation.
    @(negedge clk);
    drive_req(1'b0, 4'h0, 32'd1, 32'd2);
    req_valid = 2'b01;
    @(negedge clk);
    req_valid = 2'b00;
    rst = 1'b1;
    @(negedge clk);
    #1;
    check_idle_outputs("midreset");
    rst = 1'b0;
    rsp_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      #1;
      seen = seen | rsp_valid;
    end
    rsp_ready = 1'b0;
    exp_ops = 0;
    chk("midreset no rsp", 32'(seen), 32'd0);
    chk("midreset ops_done", 32'(ops_done), 32'd0);

    // Saturation of a 2-bit counter after 5 operations.
    for (int i = 0; i < 5; i++) run_vec(vecs[0], 100 + i);
    chk("sat ops_done", 32'(ops_done2), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
